multicycle_main_ctrl: RTL and testbench
=======================================

# multicycle_main_ctrl

Multicycle main controller FSM for the RISC-V core. It sits directly upstream of the ALU decoder. It sequences each instruction through fetch, decode, execute, memory and writeback cycles. It drives all datapath enables and mux selects, plus the 2-bit `ALUop` that the ALU decoder turns into `ALUctrl`.

## Interface
- No parameters.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `op` in 7: instruction opcode, instr[6:0], from the instruction register.
- `funct3` in 3: instr[14:12]; only bit 0 is used (beq/bne select).
- `zero` in 1: ALU zero flag, combinational from the current cycle.
- `ALUop` out 2: 00 add, 01 subtract, 10 decode by funct (to ALU decoder).
- `ALUSrcA` out 2: 00 PC, 01 OldPC, 10 rs1 register.
- `ALUSrcB` out 2: 00 rs2 register, 01 ImmExt, 10 constant 4.
- `ResultSrc` out 2: 00 ALUOut, 01 Data register, 10 ALUResult.
- `ImmSrc` out 2: 00 I, 01 S, 10 B, 11 J; combinational from `op` only.
- `AdrSrc` out 1: memory address select, 0 PC, 1 Result.
- `IRWrite`, `PCWrite`, `MemWrite`, `RegWrite` out 1 each: write enables.
- `illegal` out 1: illegal-opcode flag (see Configuration).

## Operation
- Moore FSM. `PCWrite = PCUpdate | (Branch & (zero ^ funct3[0]))`.
- `PCUpdate` and `Branch` are internal per-state signals.
- Unlisted outputs are 0 in every state; mux selects not listed are 00.
- **FETCH**: AdrSrc=0, IRWrite=1, SrcA=00, SrcB=10, ALUop=00, ResultSrc=10, PCUpdate=1. Next state is DECODE.
- **DECODE**: SrcA=01, SrcB=01, ALUop=00; computes the branch/jal target. Next state by `op`:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - any other opcode → illegal handling.
- **MEMADR**: SrcA=10, SrcB=01, ALUop=00. Next state is MEMREAD if op[5]=0, otherwise MEMWRITE.
- **MEMREAD**: ResultSrc=00, AdrSrc=1. Next state is MEMWB.
- **MEMWB**: ResultSrc=01, RegWrite=1. Next state is FETCH.
- **MEMWRITE**: ResultSrc=00, AdrSrc=1, MemWrite=1. Next state is FETCH.
- **EXECR**: SrcA=10, SrcB=00, ALUop=10. Next state is ALUWB.
- **EXECI**: SrcA=10, SrcB=01, ALUop=10. Next state is ALUWB.
- **ALUWB**: ResultSrc=00, RegWrite=1. Next state is FETCH.
- **BRANCH**: SrcA=10, SrcB=00, ALUop=01, ResultSrc=00, Branch=1. Next state is FETCH.
  - beq when funct3[0]=0, bne when funct3[0]=1.
- **JAL**: SrcA=01, SrcB=10, ALUop=00, ResultSrc=00, PCUpdate=1. Next state is ALUWB.
  - PC is loaded from ALUOut (the target); rd receives OldPC+4.
- **JALR**: SrcA=10, SrcB=01, ALUop=00, ResultSrc=10, PCUpdate=1. Next state is JALRLINK.
  - PC is loaded with rs1+imm.
- **JALRLINK**: SrcA=01, SrcB=10, ALUop=00. Next state is ALUWB; rd receives OldPC+4.
- `ImmSrc` by opcode:
  - sw → 01
  - branch → 10
  - jal → 11
  - all others, including illegal → 00.

## Timing
- Cycles per instruction, FETCH through return to FETCH: lw 5, sw 4, R-type 4, I-type 4, branch 3, jal 4, jalr 5.
- While `rst_n`=0: state=FETCH immediately (asynchronous). IRWrite, PCWrite, MemWrite, RegWrite and illegal are forced to 0. Mux outputs show FETCH values.
- The first FETCH enable is the first rising edge after `rst_n` deasserts.
- Reset asserted mid-instruction aborts it at once. No partial write occurs after reset assertion.
- `zero` is sampled combinationally only in BRANCH; it is ignored in all other states.
- No stall or handshake inputs; memory is single-cycle.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined:
  - An illegal opcode in DECODE moves the FSM to TRAP.
  - TRAP holds all enables at 0 and drives `illegal`=1 until reset.
- Undefined:
  - An illegal opcode in DECODE returns the FSM to FETCH, executing it as a 2-cycle NOP.
  - `illegal` is tied to 0 and there is no TRAP state.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles, release → IRWrite=0 during reset; IRWrite=1 and PCWrite=1 in the first cycle after release.
- lw (op=0000011) → FETCH, DECODE, MEMADR, MEMREAD, MEMWB.
  - RegWrite=1 with ResultSrc=01 only in cycle 5.
  - MemWrite stays 0 throughout.
- R-type add (op=0110011) → ALUop=10, SrcA=10, SrcB=00 in cycle 3; RegWrite=1 in cycle 4; next FETCH in cycle 5.
- Branch (op=1100011) in the BRANCH cycle:
  - funct3=000, zero=1 → PCWrite=1
  - funct3=000, zero=0 → PCWrite=0
  - funct3=001, zero=0 → PCWrite=1
  - funct3=001, zero=1 → PCWrite=0
  - In every case ALUop=01.
- jalr (op=1100111) → PCWrite=1 with ResultSrc=10 in cycle 3; SrcA=01, SrcB=10 in cycle 4; RegWrite=1 in cycle 5.
- op=1111111:
  - With the macro, `illegal`=1 persists and enables stay 0 for 10 cycles until reset.
  - Without it, FETCH follows 1 cycle after DECODE.

Source files
------------

// File: rtl/multicycle_main_ctrl.sv
// multicycle_main_ctrl: multicycle RISC-V main control FSM driving datapath enables, mux selects and ALUop.
// Defining CTRL_ILLEGAL_TRAP_EN adds a sticky TRAP state for illegal opcodes.
module multicycle_main_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       zero,
   output logic [1:0] ALUop,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [1:0] ImmSrc,
   output logic       AdrSrc,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       illegal
);
   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMREAD  = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWRITE = 4'd5;
   localparam logic [3:0] S_EXECR    = 4'd6;
   localparam logic [3:0] S_EXECI    = 4'd7;
   localparam logic [3:0] S_ALUWB    = 4'd8;
   localparam logic [3:0] S_BRANCH   = 4'd9;
   localparam logic [3:0] S_JAL      = 4'd10;
   localparam logic [3:0] S_JALR     = 4'd11;
   localparam logic [3:0] S_JALRLINK = 4'd12;
`ifdef CTRL_ILLEGAL_TRAP_EN
   localparam logic [3:0] S_TRAP     = 4'd13;
`endif

   logic [3:0] state_q, state_d;
   logic       pc_update, branch, ir_w, mem_w, reg_w;
   logic       unused_funct3;

   assign unused_funct3 = ^funct3[2:1];

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:    state_d = S_DECODE;
         S_DECODE:
            case (op)
               7'b0000011, 7'b0100011: state_d = S_MEMADR;
               7'b0110011:             state_d = S_EXECR;
               7'b0010011:             state_d = S_EXECI;
               7'b1100011:             state_d = S_BRANCH;
               7'b1101111:             state_d = S_JAL;
               7'b1100111:             state_d = S_JALR;
`ifdef CTRL_ILLEGAL_TRAP_EN
               default:                state_d = S_TRAP;
`else
               default:                state_d = S_FETCH;
`endif
            endcase
         S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  state_d = S_MEMWB;
         S_EXECR:    state_d = S_ALUWB;
         S_EXECI:    state_d = S_ALUWB;
         S_JAL:      state_d = S_ALUWB;
         S_JALR:     state_d = S_JALRLINK;
         S_JALRLINK: state_d = S_ALUWB;
`ifdef CTRL_ILLEGAL_TRAP_EN
         S_TRAP:     state_d = S_TRAP;
`endif
         default:    state_d = S_FETCH;
      endcase
   end

   always_comb begin
      ALUop     = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      ResultSrc = 2'b00;
      AdrSrc    = 1'b0;
      pc_update = 1'b0;
      branch    = 1'b0;
      ir_w      = 1'b0;
      mem_w     = 1'b0;
      reg_w     = 1'b0;
      case (state_q)
         S_FETCH:    begin ALUSrcB = 2'b10; ResultSrc = 2'b10; ir_w = 1'b1; pc_update = 1'b1; end
         S_DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
         S_MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
         S_MEMREAD:  AdrSrc = 1'b1;
         S_MEMWB:    begin ResultSrc = 2'b01; reg_w = 1'b1; end
         S_MEMWRITE: begin AdrSrc = 1'b1; mem_w = 1'b1; end
         S_EXECR:    begin ALUSrcA = 2'b10; ALUop = 2'b10; end
         S_EXECI:    begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; ALUop = 2'b10; end
         S_ALUWB:    reg_w = 1'b1;
         S_BRANCH:   begin ALUSrcA = 2'b10; ALUop = 2'b01; branch = 1'b1; end
         S_JAL:      begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; pc_update = 1'b1; end
         S_JALR:     begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; ResultSrc = 2'b10; pc_update = 1'b1; end
         S_JALRLINK: begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; end
         default:    ;
      endcase
   end

   assign ImmSrc = (op == 7'b0100011) ? 2'b01 :
                   (op == 7'b1100011) ? 2'b10 :
                   (op == 7'b1101111) ? 2'b11 : 2'b00;

   // Enables are gated by rst_n so that asserting reset stops any write in the same cycle.
   assign IRWrite  = rst_n & ir_w;
   assign PCWrite  = rst_n & (pc_update | (branch & (zero ^ funct3[0])));
   assign MemWrite = rst_n & mem_w;
   assign RegWrite = rst_n & reg_w;
`ifdef CTRL_ILLEGAL_TRAP_EN
   assign illegal  = rst_n & (state_q == S_TRAP);
`else
   assign illegal  = 1'b0;
`endif
endmodule

// File: tb/tb_multicycle_main_ctrl.sv
// tb_multicycle_main_ctrl: table-driven, scoreboarded check of the multicycle main controller.
module tb_multicycle_main_ctrl;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] op = 7'b0110011;
   logic [2:0] funct3 = 3'b000;
   logic       zero = 1'b0;
   logic [1:0] ALUop, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
   logic       AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, illegal;

   int tests = 0;
   int fails = 0;
   logic [15:0] sb[$];

   multicycle_main_ctrl dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .zero(zero),
      .ALUop(ALUop), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
      .ImmSrc(ImmSrc), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
      .MemWrite(MemWrite), .RegWrite(RegWrite), .illegal(illegal)
   );

   always #5 clk = ~clk;

   // Packed word: {ALUop, SrcA, SrcB, ResultSrc, ImmSrc, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, illegal}
   function automatic logic [15:0] w(input logic [1:0] alu, a, b, r, input logic adr, ir, pc, mw, rw);
      return {alu, a, b, r, 2'b00, adr, ir, pc, mw, rw, 1'b0};
   endfunction

   function automatic logic [1:0] imm(input logic [6:0] o);
      return (o == 7'b0100011) ? 2'b01 : (o == 7'b1100011) ? 2'b10 : (o == 7'b1101111) ? 2'b11 : 2'b00;
   endfunction

   typedef struct {
      string            name;
      logic [6:0]       op;
      logic [2:0]       f3;
      logic             z;
      int               n;
      logic [5:0][15:0] e;
   } vec_t;

   vec_t vt[$];

   task automatic add(input string nm, input logic [6:0] o, input logic [2:0] f, input logic z, input int n,
                      input logic [15:0] w0, w1, w2, w3, w4, w5);
      vec_t v;
      v.name = nm; v.op = o; v.f3 = f; v.z = z; v.n = n;
      v.e[0] = w0; v.e[1] = w1; v.e[2] = w2; v.e[3] = w3; v.e[4] = w4; v.e[5] = w5;
      vt.push_back(v);
   endtask

   task automatic cycle(input string nm, input logic [15:0] e);
      logic [15:0] got, exp;
      sb.push_back(e | {8'b0, imm(op), 6'b0});
      #1;
      exp = sb.pop_front();
      got = {ALUop, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, illegal};
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
      @(negedge clk);
   endtask

   task automatic run(input vec_t v);
      op = v.op; funct3 = v.f3; zero = v.z;
      for (int k = 0; k < v.n; k++) cycle($sformatf("%s c%0d", v.name, k + 1), v.e[k]);
   endtask

   logic [15:0] F, D, MA, MR, MWB, MWR, ER, EI, AWB, JL, JA, JR, JK, RS;

   initial begin
      F   = w(2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      D   = w(2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      MA  = w(2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      MR  = w(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      MWB = w(2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      MWR = w(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      ER  = w(2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      EI  = w(2'b10, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      AWB = w(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      JA  = w(2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      JR  = w(2'b00, 2'b10, 2'b01, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      JK  = w(2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      RS  = w(2'b00, 2'b00, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      JL  = w(2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      add("lw",      7'b0000011, 3'b010, 1'b1, 5, F, D, MA, MR, MWB, 16'h0);
      add("sw",      7'b0100011, 3'b010, 1'b0, 4, F, D, MA, MWR, 16'h0, 16'h0);
      add("add",     7'b0110011, 3'b000, 1'b1, 4, F, D, ER, AWB, 16'h0, 16'h0);
      add("addi",    7'b0010011, 3'b000, 1'b1, 4, F, D, EI, AWB, 16'h0, 16'h0);
      add("beq_t",   7'b1100011, 3'b000, 1'b1, 3, F, D, JL | 16'h0008, 16'h0, 16'h0, 16'h0);
      add("beq_nt",  7'b1100011, 3'b000, 1'b0, 3, F, D, JL, 16'h0, 16'h0, 16'h0);
      add("bne_t",   7'b1100011, 3'b001, 1'b0, 3, F, D, JL | 16'h0008, 16'h0, 16'h0, 16'h0);
      add("bne_nt",  7'b1100011, 3'b001, 1'b1, 3, F, D, JL, 16'h0, 16'h0, 16'h0);
      add("jal",     7'b1101111, 3'b000, 1'b1, 4, F, D, JA, AWB, 16'h0, 16'h0);
      add("jalr",    7'b1100111, 3'b000, 1'b0, 5, F, D, JR, JK, AWB, 16'h0);
      add("add2",    7'b0110011, 3'b111, 1'b0, 4, F, D, ER, AWB, 16'h0, 16'h0);

      repeat (3) @(negedge clk);
      cycle("reset_hold", RS);
      rst_n = 1'b1;
      foreach (vt[i]) run(vt[i]);

      // Reset asserted during MEMWB must suppress the register write immediately.
      op = 7'b0000011; funct3 = 3'b010; zero = 1'b0;
      cycle("abort c1", F);
      cycle("abort c2", D);
      cycle("abort c3", MA);
      cycle("abort c4", MR);
      rst_n = 1'b0;
      cycle("abort_rst", RS);
      cycle("abort_rst2", RS);
      rst_n = 1'b1;
      run(vt[0]);

      op = 7'b1111111;
      cycle("illegal c1", F);
      cycle("illegal c2", D);
`ifdef CTRL_ILLEGAL_TRAP_EN
      for (int k = 0; k < 10; k++) cycle($sformatf("trap c%0d", k + 1), 16'h0001);
      rst_n = 1'b0;
      cycle("trap_rst", RS);
      rst_n = 1'b1;
`endif
      op = 7'b0110011;
      run(vt[2]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
